// File: rtl/down_sampler_n_1.sv
// Receive-side N:1 decimator with programmable capture phase.
// Keeps one matched-filter sample per symbol and flags symbol slips.
module down_sampler_n_1 #(
  parameter int WIDTH = 18,
  parameter int DECIM = 4,
  parameter int PW    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk,
  input  logic                    sym_clk,
  input  logic [PW-1:0]           phase_sel,
  input  logic signed [WIDTH-1:0] x_in,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  output logic                    locked,
  output logic                    align_err
);

  typedef enum logic {
    ACQUIRE,
    TRACK
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  state_t        state;
  logic [PW-1:0] idx;
  logic [PW-1:0] ph;
  logic [PW-1:0] eff;
  logic [PW-1:0] cmp_ph;

  // A boundary sample always restarts the count and uses the fresh phase.
  always_comb begin
    eff    = sym_clk ? '0 : idx + PW'(1);
    cmp_ph = sym_clk ? phase_sel : ph;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACQUIRE;
      idx       <= '0;
      ph        <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      locked    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      unique case (state)
        ACQUIRE: begin
          if (sam_clk && sym_clk) begin
            state  <= TRACK;
            locked <= 1'b1;
            idx    <= '0;
            ph     <= phase_sel;
            if (phase_sel == '0) begin
              y       <= x_in;
              y_valid <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (sam_clk) begin
            idx <= eff;
            if (eff == cmp_ph) begin
              y       <= x_in;
              y_valid <= 1'b1;
            end
            if (sym_clk) begin
              ph <= phase_sel;
              if (idx != LAST)
                align_err <= 1'b1;
            end
          end else if (sym_clk) begin
            align_err <= 1'b1;
          end
        end
        default: state <= ACQUIRE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_sampler_n_1.sv
// Directed bench for down_sampler_n_1 (DECIM=4).
// One sam_clk every 4th clock; outputs sampled 1ns after the edge.
module tb_down_sampler_n_1;

  localparam int WIDTH = 18;
  localparam int DECIM = 4;
  localparam int PW    = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    sam_clk;
  logic                    sym_clk;
  logic [PW-1:0]           phase_sel;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y;
  logic                    y_valid;
  logic                    locked;
  logic                    align_err;

  int checks   = 0;
  int failures = 0;
  int vcnt;
  logic                    vld;
  logic signed [WIDTH-1:0] yo;

  down_sampler_n_1 #(
    .WIDTH(WIDTH),
    .DECIM(DECIM),
    .PW   (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sam_clk  (sam_clk),
    .sym_clk  (sym_clk),
    .phase_sel(phase_sel),
    .x_in     (x_in),
    .y        (y),
    .y_valid  (y_valid),
    .locked   (locked),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample: sam_clk for one clock, then three idle clocks.
  // vld/yo hold the outputs right after the sample edge; vcnt counts
  // every y_valid seen, including during idle clocks.
  task automatic smp(input int x, input bit s);
    sam_clk = 1'b1;
    sym_clk = s;
    x_in    = WIDTH'(x);
    @(posedge clk);
    #1;
    sam_clk = 1'b0;
    sym_clk = 1'b0;
    vld = y_valid;
    yo  = y;
    if (y_valid) vcnt++;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (y_valid) vcnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    vcnt  = 0;
  endtask

  initial begin
    reset     = 1'b1;
    sam_clk   = 1'b0;
    sym_clk   = 1'b0;
    phase_sel = '0;
    x_in      = '0;
    vcnt      = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_y", y, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", align_err, 0);

    // Acquire: samples without any symbol strobe
    for (int i = 1; i <= 20; i++) smp(i, 1'b0);
    chk("acq_vcnt", vcnt, 0);
    chk("acq_y", y, 0);
    chk("acq_locked", locked, 0);

    // Nominal, phase 0: keep samples 1,5,9
    do_reset();
    phase_sel = 2'd0;
    for (int i = 1; i <= 12; i++) begin
      smp(i, (i % 4) == 1);
      chk($sformatf("nom_v%0d", i), vld, (i % 4) == 1);
      if ((i % 4) == 1) chk($sformatf("nom_y%0d", i), yo, i);
    end
    chk("nom_vcnt", vcnt, 3);
    chk("nom_locked", locked, 1);
    chk("nom_err", align_err, 0);

    // Phase 2: keep samples 3,7,11
    do_reset();
    phase_sel = 2'd2;
    for (int i = 1; i <= 12; i++) begin
      smp(i, (i % 4) == 1);
      chk($sformatf("ph2_v%0d", i), vld, (i % 4) == 3);
      if ((i % 4) == 3) chk($sformatf("ph2_y%0d", i), yo, i);
    end
    chk("ph2_err", align_err, 0);

    // Phase change 0->3 during sample 6 applies from boundary 9
    do_reset();
    phase_sel = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      smp(i, (i % 4) == 1);
      if (i == 6) phase_sel = 2'd3;
      if (i == 5) chk("pc_y5", yo, 5);
      if (i == 10) chk("pc_hold10", yo, 5);
      if (i == 12) begin
        chk("pc_v12", vld, 1);
        chk("pc_y12", yo, 12);
      end
      if (i == 16) begin
        chk("pc_v16", vld, 1);
        chk("pc_y16", yo, 16);
      end
    end
    chk("pc_err", align_err, 0);

    // Early boundary on sample 12 instead of 13
    do_reset();
    phase_sel = 2'd0;
    for (int i = 1; i <= 20; i++) begin
      smp(i, i == 1 || i == 5 || i == 9 || i == 12 || i == 16 || i == 20);
      if (i == 11) chk("slip_err_pre", align_err, 0);
      if (i == 12) begin
        chk("slip_v12", vld, 1);
        chk("slip_y12", yo, 12);
        chk("slip_err12", align_err, 1);
      end
      if (i == 13) chk("slip_v13", vld, 0);
      if (i == 16) chk("slip_y16", yo, 16);
      if (i == 20) chk("slip_y20", yo, 20);
    end
    chk("slip_err_sticky", align_err, 1);
    chk("slip_locked", locked, 1);

    // Symbol strobe without a sample flags an error, y untouched
    do_reset();
    smp(-7, 1'b1);
    chk("neg_y", yo, -7);
    chk("lone_err_pre", align_err, 0);
    sym_clk = 1'b1;
    @(posedge clk);
    #1;
    sym_clk = 1'b0;
    chk("lone_err", align_err, 1);
    chk("lone_valid", y_valid, 0);
    chk("lone_y", y, -7);

    // Reset during sample 7 with y=5
    do_reset();
    phase_sel = 2'd0;
    for (int i = 1; i <= 6; i++) smp(i, (i % 4) == 1);
    chk("mid_y5", y, 5);
    reset = 1'b1;
    smp(7, 1'b0);
    chk("mid_y0", yo, 0);
    chk("mid_locked", locked, 0);
    chk("mid_valid", vld, 0);
    reset = 1'b0;
    vcnt  = 0;
    for (int i = 8; i <= 12; i++) smp(i, 1'b0);
    chk("mid_vcnt", vcnt, 0);
    chk("mid_locked2", locked, 0);
    smp(13, 1'b1);
    chk("mid_v13", vld, 1);
    chk("mid_y13", yo, 13);
    chk("mid_locked3", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
